// File: rtl/aes_stream_pkg.sv
// Shared types and helpers for the AES-128 stream engine: FSM encoding,
// block/key widths and the channel-index width helper.
package aes_stream_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aes128_core.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key
// expansion; done pulses for one cycle with the ciphertext on result.
module aes128_core import aes_stream_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key,
  input  logic [AES_BLK_W-1:0] text,
  output logic [AES_BLK_W-1:0] result,
  output logic                 done
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, inv;
    p   = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] rot, t, n0, n1, n2, n3;
    rot = {k[23:0], k[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    n0  = k[127:96] ^ t;
    n1  = k[95:64] ^ n0;
    n2  = k[63:32] ^ n1;
    n3  = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        t[4*c+rw] = b[4*((c+rw)%4)+rw];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last) begin
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return r;
  endfunction

  logic [127:0] state, rk, nrk, rnd;
  logic [7:0]   rcon;
  logic [3:0]   round;
  logic         running;

  assign nrk = next_key(rk, rcon);
  assign rnd = round_fn(state, round == 4'd10) ^ nrk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= '0;
      rk      <= '0;
      rcon    <= '0;
      round   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state   <= text ^ key;
        rk      <= key;
        rcon    <= 8'h01;
        round   <= 4'd1;
        running <= 1'b1;
      end else if (running) begin
        state <= rnd;
        rk    <= nrk;
        rcon  <= xtime(rcon);
        round <= round + 4'd1;
        if (round == 4'd10) begin
          running <= 1'b0;
          done    <= 1'b1;
          result  <= rnd;
        end
      end
    end
  end

endmodule

// File: rtl/aes_stream_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head entry is always visible on rdata.
module aes_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/aes128_stream_engine.sv
// Multi-channel buffered AES-128 stream engine (ECB by default, CTR mode when
// AES_STREAM_CTR_EN is defined) around the iterative aes128_core.
module aes128_stream_engine import aes_stream_pkg::*; #(
  parameter  int NUM_CH     = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic                 pi_clk,
  input  logic                 pi_rst,
  input  logic                 pi_key_we,
  input  logic [CH_W-1:0]      pi_key_sel,
  input  logic [AES_KEY_W-1:0] pi_key,
  input  logic [AES_BLK_W-1:0] pi_iv,
  input  logic                 pi_in_valid,
  output logic                 po_in_ready,
  input  logic [AES_BLK_W-1:0] pi_in_data,
  input  logic [CH_W-1:0]      pi_in_ch,
  output logic                 po_out_valid,
  input  logic                 pi_out_ready,
  output logic [AES_BLK_W-1:0] po_out_data,
  output logic [CH_W-1:0]      po_out_ch,
  output logic                 po_busy
);

  state_t                      state, next_state;
  logic                        fifo_full, fifo_empty, pop, core_start, core_done, key_ok;
  logic [CH_W+AES_BLK_W-1:0]   head;
  logic [CH_W-1:0]             head_ch, op_ch;
  logic [AES_BLK_W-1:0]        head_data, op_data, core_text, core_result, result_data;
  logic [AES_KEY_W-1:0]        op_key;
  logic [AES_KEY_W-1:0]        key_mem [NUM_CH];

  assign key_ok      = pi_key_we && (int'(pi_key_sel) < NUM_CH);
  assign head_ch     = head[CH_W+AES_BLK_W-1:AES_BLK_W];
  assign head_data   = head[AES_BLK_W-1:0];
  assign po_in_ready = !fifo_full;
  assign po_busy     = (state != IDLE) || !fifo_empty || po_out_valid;

  aes_stream_fifo #(.W(CH_W + AES_BLK_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(pi_clk), .rst(pi_rst), .push(pi_in_valid), .pop(pop),
    .wdata({pi_in_ch, pi_in_data}), .rdata(head), .full(fifo_full), .empty(fifo_empty)
  );

  aes128_core u_core (
    .clk(pi_clk), .rst(pi_rst), .start(core_start), .key(op_key),
    .text(core_text), .result(core_result), .done(core_done)
  );

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Dispatch only when the output register is free or being drained this cycle
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    core_start = 1'b0;
    case (state)
      IDLE: if (!fifo_empty && (!po_out_valid || pi_out_ready)) begin
        pop        = 1'b1;
        next_state = LOAD;
      end
      LOAD: begin
        core_start = 1'b1;
        next_state = RUN;
      end
      RUN:  if (core_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      for (int i = 0; i < NUM_CH; i++) key_mem[i] <= '0;
    end else if (key_ok) begin
      key_mem[pi_key_sel] <= pi_key;
    end
  end

  // Operands are snapshotted at dispatch so later key writes never disturb the block in flight
  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      op_data <= '0;
      op_ch   <= '0;
      op_key  <= '0;
    end else if (pop) begin
      op_data <= head_data;
      op_ch   <= head_ch;
      op_key  <= key_mem[head_ch];
    end
  end

`ifdef AES_STREAM_CTR_EN
  logic [AES_BLK_W-1:0] ctr_mem [NUM_CH];
  logic [AES_BLK_W-1:0] op_ctr;

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      for (int i = 0; i < NUM_CH; i++) ctr_mem[i] <= '0;
      op_ctr <= '0;
    end else begin
      if (pop) op_ctr <= ctr_mem[head_ch];
      for (int i = 0; i < NUM_CH; i++) begin
        if (key_ok && pi_key_sel == CH_W'(i))
          ctr_mem[i] <= pi_iv;
        else if (pop && head_ch == CH_W'(i))
          ctr_mem[i] <= ctr_mem[i] + 1'b1;
      end
    end
  end

  assign core_text   = op_ctr;
  assign result_data = core_result ^ op_data;
`else
  logic unused_iv;
  assign unused_iv   = ^pi_iv;
  assign core_text   = op_data;
  assign result_data = core_result;
`endif

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      po_out_valid <= 1'b0;
      po_out_data  <= '0;
      po_out_ch    <= '0;
    end else if (state == RUN && core_done) begin
      po_out_valid <= 1'b1;
      po_out_data  <= result_data;
      po_out_ch    <= op_ch;
    end else if (pi_out_ready) begin
      po_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes128_stream_engine.sv
// Self-checking bench for aes128_stream_engine against a table-driven AES reference model.
module tb_aes128_stream_engine;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 2;

  logic              pi_clk = 1'b0;
  logic              pi_rst;
  logic              pi_key_we;
  logic [CH_W-1:0]   pi_key_sel;
  logic [127:0]      pi_key, pi_iv;
  logic              pi_in_valid;
  logic              po_in_ready;
  logic [127:0]      pi_in_data;
  logic [CH_W-1:0]   pi_in_ch;
  logic              po_out_valid;
  logic              pi_out_ready = 1'b0;
  logic [127:0]      po_out_data;
  logic [CH_W-1:0]   po_out_ch;
  logic              po_busy;

  int checkCount = 0;
  int errorCount = 0;
  int readyMode  = 0;

  logic [7:0]          sboxTable [256];
  logic [127:0]        keyModel [NUM_CH];
  logic [127:0]        ctrModel [NUM_CH];
  logic [CH_W+127:0]   expQueue [$];

  aes128_stream_engine dut (
    .pi_clk(pi_clk), .pi_rst(pi_rst), .pi_key_we(pi_key_we), .pi_key_sel(pi_key_sel),
    .pi_key(pi_key), .pi_iv(pi_iv), .pi_in_valid(pi_in_valid), .po_in_ready(po_in_ready),
    .pi_in_data(pi_in_data), .pi_in_ch(pi_in_ch), .po_out_valid(po_out_valid),
    .pi_out_ready(pi_out_ready), .po_out_data(po_out_data), .po_out_ch(po_out_ch),
    .po_busy(po_busy)
  );

  always #5 pi_clk = ~pi_clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference AES-128: full key schedule up front, table S-box, matrix MixColumns
  function automatic logic [127:0] aesRef(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [7:0]   rc, acc;
    logic [31:0]  tmp;
    logic [127:0] r;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sboxTable[tmp[31:24]], sboxTable[tmp[23:16]],
               sboxTable[tmp[15:8]], sboxTable[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gfMul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sboxTable[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
      if (rnd < 10) begin
        for (int i = 0; i < 16; i++) t[i] = s[i];
        for (int c = 0; c < 4; c++)
          for (int rw = 0; rw < 4; rw++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc ^= gfMul(coef[(k - rw + 4) % 4], t[4*c+k]);
            s[4*c+rw] = acc;
          end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic buildSbox();
    logic [7:0] p = 8'h01;
    logic [7:0] q = 8'h01;
    logic [7:0] x;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sboxTable[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxTable[0] = 8'h63;
  endtask

  task automatic resetModel();
    expQueue.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      keyModel[i] = '0;
      ctrModel[i] = '0;
    end
  endtask

  // Sink-ready driver: 0 = stalled, 1 = always ready, otherwise random
  always @(posedge pi_clk) begin
    #1;
    case (readyMode)
      0:       pi_out_ready = 1'b0;
      1:       pi_out_ready = 1'b1;
      default: pi_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: each accepted result must be the oldest expected one
  always @(negedge pi_clk) begin
    logic [CH_W+127:0] e;
    if (!pi_rst && po_out_valid && pi_out_ready) begin
      checkOutput("result_expected", 128'(expQueue.size() != 0), 128'd1);
      if (expQueue.size() != 0) begin
        e = expQueue.pop_front();
        checkOutput("out_data", po_out_data, e[127:0]);
        checkOutput("out_ch", 128'(po_out_ch), 128'(e[CH_W+127:128]));
      end
    end
  end

  task automatic writeKey(input logic [CH_W-1:0] slot, input logic [127:0] key, input logic [127:0] iv);
    @(posedge pi_clk); #1;
    pi_key_we = 1'b1; pi_key_sel = slot; pi_key = key; pi_iv = iv;
    @(posedge pi_clk); #1;
    pi_key_we = 1'b0;
    keyModel[slot] = key;
    ctrModel[slot] = iv;
  endtask

  // Offers one block for up to budget cycles; records the expected result when accepted
  task automatic applyStimulus(input logic [127:0] data, input logic [CH_W-1:0] ch,
                               input int budget, output bit ok);
    logic [127:0] e;
    ok = 1'b0;
    pi_in_valid = 1'b1; pi_in_data = data; pi_in_ch = ch;
    for (int n = 0; n < budget; n++) begin
      @(negedge pi_clk);
      if (po_in_ready) begin
        ok = 1'b1;
`ifdef AES_STREAM_CTR_EN
        e = aesRef(keyModel[ch], ctrModel[ch]) ^ data;
        ctrModel[ch] = ctrModel[ch] + 128'd1;
`else
        e = aesRef(keyModel[ch], data);
`endif
        expQueue.push_back({ch, e});
      end
      @(posedge pi_clk); #1;
      if (ok) break;
    end
    pi_in_valid = 1'b0;
  endtask

  task automatic pushChecked(input logic [127:0] data, input logic [CH_W-1:0] ch);
    bit ok;
    applyStimulus(data, ch, 300, ok);
    checkOutput("push_accepted", 128'(ok), 128'd1);
  endtask

  task automatic waitIdle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge pi_clk);
      if (!po_busy) break;
    end
    checkOutput("drain_busy", 128'(po_busy), 128'd0);
    checkOutput("drain_queue", 128'(expQueue.size()), 128'd0);
    @(posedge pi_clk); #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, 128'(po_out_valid), 128'd0);
    checkOutput({tag, "_out_data"}, po_out_data, 128'd0);
    checkOutput({tag, "_out_ch"}, 128'(po_out_ch), 128'd0);
    checkOutput({tag, "_in_ready"}, 128'(po_in_ready), 128'd1);
    checkOutput({tag, "_busy"}, 128'(po_busy), 128'd0);
  endtask

  task automatic fipsVector();
`ifndef AES_STREAM_CTR_EN
    writeKey(0, 128'h000102030405060708090a0b0c0d0e0f, '0);
    pushChecked(128'h00112233445566778899aabbccddeeff, 0);
    for (int n = 0; n < 60; n++) begin
      @(negedge pi_clk);
      if (po_out_valid) break;
    end
    checkOutput("c1_valid", 128'(po_out_valid), 128'd1);
    checkOutput("c1_data", po_out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    checkOutput("c1_ch", 128'(po_out_ch), 128'd0);
    @(posedge pi_clk); #1;
`else
    writeKey(0, 128'h000102030405060708090a0b0c0d0e0f, '1);
    pushChecked('0, 0);
    pushChecked('0, 0);
`endif
    waitIdle(300);
  endtask

  initial begin
    bit               ok;
    int               accepts;
    logic [127:0]     held;
    logic [127:0]     bpData [DEPTH+2];
    logic [CH_W-1:0]  bpCh   [DEPTH+2];
    logic [CH_W-1:0]  order  [4];

    buildSbox();
    resetModel();
    pi_rst = 1'b1; pi_key_we = 1'b0; pi_key_sel = '0; pi_key = '0; pi_iv = '0;
    pi_in_valid = 1'b0; pi_in_data = '0; pi_in_ch = '0;
    repeat (3) @(posedge pi_clk);
    @(negedge pi_clk);
    checkResetValues("reset");
    @(posedge pi_clk); #1;
    pi_rst = 1'b0;

    $display("[TB] known-answer vector");
    readyMode = 1;
    fipsVector();

    $display("[TB] back-pressure");
    readyMode = 0;
    @(posedge pi_clk); #1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      bpData[k] = {$urandom, $urandom, $urandom, $urandom};
      bpCh[k]   = CH_W'($urandom_range(0, NUM_CH - 1));
    end
    accepts = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      applyStimulus(bpData[k], bpCh[k], 30, ok);
      if (!ok) break;
      accepts++;
    end
    checkOutput("bp_accepts", 128'(accepts), 128'(DEPTH + 1));
    @(negedge pi_clk);
    checkOutput("bp_in_ready", 128'(po_in_ready), 128'd0);
    checkOutput("bp_out_valid", 128'(po_out_valid), 128'd1);
    held = po_out_data;
    repeat (10) @(negedge pi_clk);
    checkOutput("bp_out_stable", po_out_data, held);
    @(posedge pi_clk); #1;
    readyMode = 1;
    if (accepts < DEPTH + 2) pushChecked(bpData[accepts], bpCh[accepts]);
    waitIdle(500);

    $display("[TB] key rewrite during encryption");
    writeKey(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    pushChecked({$urandom, $urandom, $urandom, $urandom}, 1);
    repeat (4) @(posedge pi_clk); #1;
    writeKey(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    pushChecked({$urandom, $urandom, $urandom, $urandom}, 1);
    waitIdle(300);

    $display("[TB] multi-channel interleave");
    for (int c = 0; c < NUM_CH; c++)
      writeKey(CH_W'(c), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    order[0] = 3; order[1] = 0; order[2] = 2; order[3] = 1;
    for (int k = 0; k < 4; k++) pushChecked({$urandom, $urandom, $urandom, $urandom}, order[k]);
    waitIdle(500);

    $display("[TB] random traffic");
    readyMode = 2;
    for (int it = 0; it < 40; it++) begin
      pushChecked({$urandom, $urandom, $urandom, $urandom}, CH_W'($urandom_range(0, NUM_CH - 1)));
      if (it % 10 == 9) begin
        waitIdle(1000);
        writeKey(CH_W'($urandom_range(0, NUM_CH - 1)), {$urandom, $urandom, $urandom, $urandom},
                 (it == 19) ? '1 : {$urandom, $urandom, $urandom, $urandom});
      end
    end
    waitIdle(1000);

    $display("[TB] reset during encryption");
    readyMode = 1;
    writeKey(2, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    pushChecked({$urandom, $urandom, $urandom, $urandom}, 2);
    repeat (5) @(posedge pi_clk);
    #1;
    pi_rst = 1'b1;
    resetModel();
    #1;
    checkResetValues("midrun_reset");
    @(posedge pi_clk); #1;
    pi_rst = 1'b0;
    fipsVector();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
